euler_mac_sequencer: RTL and testbench

- Controller that sequences the shared multiplier → mul/acc buffer → accumulator datapath to compute one matrix-vector product y = A·x per Euler step, issuing one multiply per element and one accumulate per product.
- Sits between the Euler step controller (start/done) and the MAC datapath.
- Drives operand indices, multiplier start, accumulator clear/enable, and a per-row result strobe.

---
 rtl/euler_pkg.sv | 26 ++
 rtl/euler_mac_sequencer_if.sv | 33 +++
 rtl/mac_index_counter.sv | 39 +++
 rtl/euler_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_euler_mac_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/euler_pkg.sv
// Shared constants, FSM state encoding and n_dim range check for the MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package euler_pkg;

  localparam int MaxDim        = 8;
  localparam int IdxW          = 3;
  localparam int DimW          = 4;
  localparam int TimeoutCycDef = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_CLR,
    S_ISSUE,
    S_WAIT_MUL,
    S_ACC,
    S_ROW_DONE,
    S_FINISH
  } seq_state_t;

  // A product request is only accepted for 1 <= n <= MaxDim.
  function automatic logic dim_ok(input logic [DimW-1:0] n);
    return (n != '0) && (n <= DimW'(MaxDim));
  endfunction

endpackage

// File: rtl/euler_mac_sequencer_if.sv
// Control and datapath-strobe bundle between the Euler step controller, the sequencer and the MAC datapath.
// Latency: n/a (wires only).
// Backpressure: none; mul_done is the only return handshake from the datapath.
interface euler_mac_sequencer_if;
  import euler_pkg::*;

  logic            start;
  logic            abort;
  logic [DimW-1:0] n_dim;
  logic            mul_done;
  logic            busy;
  logic            done;
  logic            err;
  logic            mul_start;
  logic            acc_clr;
  logic            acc_en;
  logic [IdxW-1:0] op_row;
  logic [IdxW-1:0] op_col;
  logic            row_valid;

  // Sequencer side.
  modport master (
    input  start, abort, n_dim, mul_done,
    output busy, done, err, mul_start, acc_clr, acc_en, op_row, op_col, row_valid
  );

  // Controller/datapath side.
  modport slave (
    output start, abort, n_dim, mul_done,
    input  busy, done, err, mul_start, acc_clr, acc_en, op_row, op_col, row_valid
  );

endinterface

// File: rtl/mac_index_counter.sv
// Nested row/column operand index counter with last-row/last-column flags.
// Latency: indices update one cycle after clr/col_clr/col_inc/row_inc.
// Backpressure: none; the sequencer FSM decides when to step.
module mac_index_counter
  import euler_pkg::*;
(
  input  logic            clk,
  input  logic            rst_sync,
  input  logic            clr,
  input  logic            col_clr,
  input  logic            col_inc,
  input  logic            row_inc,
  input  logic [DimW-1:0] n_lat,
  output logic [IdxW-1:0] row,
  output logic [IdxW-1:0] col,
  output logic            last_col,
  output logic            last_row
);

  // n_lat is at least 1 whenever the flags are consulted, so n_lat-1 never wraps in use.
  assign last_col = (DimW'(col) == (n_lat - DimW'(1)));
  assign last_row = (DimW'(row) == (n_lat - DimW'(1)));

  // Full clear on a new product; column clears per row; increments never pass n-1.
  always_ff @(posedge clk) begin
    if (!rst_sync) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else begin
      if (col_clr)      col <= '0;
      else if (col_inc) col <= col + IdxW'(1);
      if (row_inc)      row <= row + IdxW'(1);
    end
  end

endmodule

// File: rtl/euler_mac_sequencer.sv
// Sequences multiplier -> mul/acc buffer -> accumulator to compute y = A*x, one multiply and one accumulate per element.
// Latency: n*(2 + n*(L+2)) + 1 cycles from first busy cycle through done, L = mul_start-to-mul_done delay.
// Backpressure: waits in WAIT_MUL for mul_done, bounded by TimeoutCyc; start while busy is ignored.
module euler_mac_sequencer
  import euler_pkg::*;
#(
  parameter int TimeoutCyc = TimeoutCycDef
) (
  input logic                   clk,
  input logic                   rst_sync,
  euler_mac_sequencer_if.master bus
);

  localparam int TmoW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;

  seq_state_t      state;
  logic [DimW-1:0] n_lat;
  logic [TmoW-1:0] tmo_cnt;
  logic            busy_q, done_q, err_q;
  logic            mul_start_q, acc_clr_q, acc_en_q, row_valid_q;
  logic            start_ok, col_clr, col_inc, row_inc;
  logic            last_col, last_row;
  logic [IdxW-1:0] row_idx, col_idx;

  assign start_ok = (state == S_IDLE) && bus.start && dim_ok(bus.n_dim);
  assign col_clr  = (state == S_ROW_CLR)  && !bus.abort;
  assign col_inc  = (state == S_ACC)      && !last_col && !bus.abort;
  assign row_inc  = (state == S_ROW_DONE) && !last_row && !bus.abort;

  mac_index_counter u_idx (
    .clk      (clk),
    .rst_sync (rst_sync),
    .clr      (start_ok),
    .col_clr  (col_clr),
    .col_inc  (col_inc),
    .row_inc  (row_inc),
    .n_lat    (n_lat),
    .row      (row_idx),
    .col      (col_idx),
    .last_col (last_col),
    .last_row (last_row)
  );

  // Control FSM; every strobe is registered so it is high exactly while in its state.
  always_ff @(posedge clk) begin
    if (!rst_sync) begin
      state       <= S_IDLE;
      n_lat       <= '0;
      tmo_cnt     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      row_valid_q <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              if (dim_ok(bus.n_dim)) begin
                n_lat     <= bus.n_dim;
                err_q     <= 1'b0;
                busy_q    <= 1'b1;
                acc_clr_q <= 1'b1;
                state     <= S_ROW_CLR;
              end else begin
                // Rejected request still completes the handshake with done, flagged by err.
                err_q  <= 1'b1;
                done_q <= 1'b1;
              end
            end
          end
          S_ROW_CLR: begin
            mul_start_q <= 1'b1;
            state       <= S_ISSUE;
          end
          S_ISSUE: begin
            tmo_cnt <= '0;
            state   <= S_WAIT_MUL;
          end
          S_WAIT_MUL: begin
            if (bus.mul_done) begin
              // ACC lands one cycle later so the negedge buffer has already captured the product.
              acc_en_q <= 1'b1;
              state    <= S_ACC;
            end else if (tmo_cnt == TmoW'(TimeoutCyc - 1)) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TmoW'(1);
            end
          end
          S_ACC: begin
            if (!last_col) begin
              mul_start_q <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              row_valid_q <= 1'b1;
              state       <= S_ROW_DONE;
            end
          end
          S_ROW_DONE: begin
            if (!last_row) begin
              acc_clr_q <= 1'b1;
              state     <= S_ROW_CLR;
            end else begin
              done_q <= 1'b1;
              state  <= S_FINISH;
            end
          end
          S_FINISH: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mul_start = mul_start_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.row_valid = row_valid_q;
  assign bus.op_row    = row_idx;
  assign bus.op_col    = col_idx;

endmodule

// File: tb/tb_euler_mac_sequencer.sv
// Scoreboard bench for euler_mac_sequencer: stimulus queues expected strobe events, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: multiplier stub models pulse latency L, never-done, hold-high and manual mul_done.
module tb_euler_mac_sequencer;
  import euler_pkg::*;

  logic clk = 1'b0;
  logic rst_sync = 1'b0;
  always #5 clk = ~clk;

  euler_mac_sequencer_if bus();

  euler_mac_sequencer #(.TimeoutCyc(64)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  typedef enum int {EV_CLR, EV_MUL, EV_ACC, EV_ROWV, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       row;
    int       col;
    int       at;
  } ev_t;

  ev_t  expq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stub_mode = 0;   // 0 never, 1 pulse after stub_lat, 2 hold high, 3 manual
  int   stub_lat = 1;
  int   stub_cnt = 0;
  logic manual_done = 1'b0;

  // Cycle counter: value c is visible throughout the cycle after the c-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int r, input int c, input int at);
    ev_t e;
    e.kind = k; e.row = r; e.col = c; e.at = at;
    expq.push_back(e);
  endtask

  // Expected strobe timeline of a full run started in cycle t0 with multiplier latency lat.
  task automatic push_run(input int t0, input int n, input int lat);
    int p = lat + 2;
    int r = 2 + n * p;
    int s;
    for (int i = 0; i < n; i++) begin
      s = t0 + 1 + i * r;
      push(EV_CLR, i, 0, s);
      for (int c = 0; c < n; c++) begin
        push(EV_MUL, i, c, s + 1 + c * p);
        push(EV_ACC, i, c, s + 1 + c * p + lat + 1);
      end
      push(EV_ROWV, i, 0, s + 1 + n * p);
    end
    push(EV_DONE, 0, 0, t0 + 1 + n * r);
  endtask

  task automatic see(input ev_kind_t k);
    ev_t e;
    int  r, c;
    logic ok;
    r = int'(bus.op_row);
    c = int'(bus.op_col);
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL event_unexpected: got %s row=%0d col=%0d at cyc %0d, required no event", k.name(), r, c, cyc);
    end else begin
      e = expq.pop_front();
      ok = (e.kind == k) && (e.at == cyc);
      if (k == EV_MUL || k == EV_ACC || k == EV_ROWV || k == EV_CLR) ok = ok && (e.row == r);
      if (k == EV_MUL || k == EV_ACC) ok = ok && (e.col == c);
      if (!ok) begin
        n_bad++;
        $display("FAIL event_%s: got %s row=%0d col=%0d cyc=%0d, required %s row=%0d col=%0d cyc=%0d",
                 e.kind.name(), k.name(), r, c, cyc, e.kind.name(), e.row, e.col, e.at);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.acc_clr   === 1'b1) see(EV_CLR);
    if (bus.mul_start === 1'b1) see(EV_MUL);
    if (bus.acc_en    === 1'b1) see(EV_ACC);
    if (bus.row_valid === 1'b1) see(EV_ROWV);
    if (bus.done      === 1'b1) see(EV_DONE);
  end

  // Multiplier stub.
  initial begin
    bus.mul_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (stub_mode)
        1: begin
          bus.mul_done = 1'b0;
          if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) bus.mul_done = 1'b1;
          end
          if (bus.mul_start) stub_cnt = stub_lat;
        end
        2:       bus.mul_done = 1'b1;
        3:       bus.mul_done = manual_done;
        default: bus.mul_done = 1'b0;
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_start(input int n, output int t0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_dim = DimW'(n);
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic set_stub(input int mode, input int lat);
    stub_mode = mode;
    stub_lat  = lat;
    stub_cnt  = 0;
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.busy, bus.done, bus.mul_start, bus.acc_clr, bus.acc_en, bus.row_valid});
  endfunction

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.n_dim = '0;
    rst_sync  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", strobes(), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    chk("reset_idx", 32'({bus.op_row, bus.op_col}), 32'h0);
    @(posedge clk); #1;
    rst_sync = 1'b1;

    // n=2, L=3: hand-computed timeline.
    set_stub(1, 3);
    do_start(2, t0);
    push(EV_CLR, 0, 0, t0 + 1);
    push(EV_MUL, 0, 0, t0 + 2);  push(EV_ACC, 0, 0, t0 + 6);
    push(EV_MUL, 0, 1, t0 + 7);  push(EV_ACC, 0, 1, t0 + 11);
    push(EV_ROWV, 0, 0, t0 + 12);
    push(EV_CLR, 1, 0, t0 + 13);
    push(EV_MUL, 1, 0, t0 + 14); push(EV_ACC, 1, 0, t0 + 18);
    push(EV_MUL, 1, 1, t0 + 19); push(EV_ACC, 1, 1, t0 + 23);
    push(EV_ROWV, 1, 0, t0 + 24);
    push(EV_DONE, 0, 0, t0 + 25);
    goto(t0 + 1);  chk("t1_busy_first", 32'(bus.busy), 32'h1);
    goto(t0 + 25); chk("t1_busy_last", 32'(bus.busy), 32'h1);
    goto(t0 + 26); chk("t1_busy_after", 32'(bus.busy), 32'h0);
    chk("t1_err", 32'(bus.err), 32'h0);
    chk("t1_drain", 32'(expq.size()), 32'h0);

    // Bad dimensions: n=0 then n=9, then a good n=1 run clears err.
    do_start(0, t0);
    push(EV_DONE, 0, 0, t0 + 1);
    goto(t0 + 1);
    chk("bad0_err", 32'(bus.err), 32'h1);
    chk("bad0_busy", 32'(bus.busy), 32'h0);
    do_start(9, t0);
    push(EV_DONE, 0, 0, t0 + 1);
    goto(t0 + 2);
    chk("bad9_err", 32'(bus.err), 32'h1);
    chk("bad9_busy", 32'(bus.busy), 32'h0);
    do_start(1, t0);
    push_run(t0, 1, 3);
    goto(t0 + 1);  chk("n1_err_cleared", 32'(bus.err), 32'h0);
    goto(t0 + 9);  chk("n1_busy_after", 32'(bus.busy), 32'h0);
    chk("n1_drain", 32'(expq.size()), 32'h0);

    // Timeout: mul_done never arrives.
    set_stub(0, 1);
    do_start(2, t0);
    push(EV_CLR, 0, 0, t0 + 1);
    push(EV_MUL, 0, 0, t0 + 2);
    goto(t0 + 66);
    chk("tmo_busy_last_wait", 32'(bus.busy), 32'h1);
    chk("tmo_err_pending", 32'(bus.err), 32'h0);
    goto(t0 + 67);
    chk("tmo_busy_idle", 32'(bus.busy), 32'h0);
    chk("tmo_err", 32'(bus.err), 32'h1);
    goto(t0 + 70);
    chk("tmo_drain", 32'(expq.size()), 32'h0);

    // Abort during the second WAIT_MUL of n=3, L=2; then a full 3x3 run.
    set_stub(1, 2);
    do_start(3, t0);
    push(EV_CLR, 0, 0, t0 + 1);
    push(EV_MUL, 0, 0, t0 + 2);
    push(EV_ACC, 0, 0, t0 + 5);
    push(EV_MUL, 0, 1, t0 + 6);
    goto(t0 + 7);
    chk("abort_busy_before", 32'(bus.busy), 32'h1);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_strobes", strobes(), 32'h0);
    goto(t0 + 12);
    chk("abort_drain", 32'(expq.size()), 32'h0);
    set_stub(1, 2);
    do_start(3, t0);
    push_run(t0, 3, 2);
    goto(t0 + 44);
    chk("n3_busy_after", 32'(bus.busy), 32'h0);
    chk("n3_err", 32'(bus.err), 32'h0);
    chk("n3_drain", 32'(expq.size()), 32'h0);

    // Reset during the ACC of (0,1), then mul_done pulses while idle.
    set_stub(1, 1);
    do_start(2, t0);
    push(EV_CLR, 0, 0, t0 + 1);
    push(EV_MUL, 0, 0, t0 + 2); push(EV_ACC, 0, 0, t0 + 4);
    push(EV_MUL, 0, 1, t0 + 5); push(EV_ACC, 0, 1, t0 + 7);
    goto(t0 + 7);
    chk("rst_in_acc_col", 32'(bus.op_col), 32'h1);
    rst_sync = 1'b0;
    @(posedge clk); #1;
    rst_sync = 1'b1;
    chk("rst_strobes", strobes(), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_idx", 32'({bus.op_row, bus.op_col}), 32'h0);
    set_stub(3, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      manual_done = ~manual_done;
    end
    manual_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done_busy", 32'(bus.busy), 32'h0);
    chk("idle_done_drain", 32'(expq.size()), 32'h0);

    // mul_done held high (L=1) and start re-pulsed while busy.
    set_stub(2, 1);
    do_start(2, t0);
    push_run(t0, 2, 1);
    goto(t0 + 5);
    bus.start = 1'b1;
    bus.n_dim = DimW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    goto(t0 + 17); chk("hold_busy_last", 32'(bus.busy), 32'h1);
    goto(t0 + 18); chk("hold_busy_after", 32'(bus.busy), 32'h0);
    chk("hold_err", 32'(bus.err), 32'h0);
    chk("hold_drain", 32'(expq.size()), 32'h0);

    set_stub(0, 1);
    repeat (4) @(negedge clk);
    chk("final_drain", 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
